// File: rtl/lsu_byte_lane_if.sv
// Bundles the core-side request/response signals and the data-memory port of the LSU.
// The LSU uses the slave view; the core/memory environment uses the master view.
interface lsu_byte_lane_if;
  logic        req;
  logic        we;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;
  logic        fault_pulse;
  logic        fault_valid;
  logic [31:0] fault_addr;
  logic [1:0]  fault_cause;
  logic        fault_clr;
  logic [31:0] mem_A;
  logic [31:0] mem_WD;
  logic        mem_WE;
  logic [31:0] mem_RD;

  modport slave (
    input  req, we, funct3, addr, wdata, fault_clr, mem_RD,
    output rdata, stall, fault_pulse, fault_valid, fault_addr, fault_cause,
    output mem_A, mem_WD, mem_WE
  );

  modport master (
    output req, we, funct3, addr, wdata, fault_clr, mem_RD,
    input  rdata, stall, fault_pulse, fault_valid, fault_addr, fault_cause,
    input  mem_A, mem_WD, mem_WE
  );
endinterface

// File: rtl/lsu_byte_lane.sv
// Load/store unit: byte-address to word-index translation, load extension, two-cycle
// read-modify-write for sb/sh, and a sticky record of the first rejected access.
module lsu_byte_lane #(
  parameter int MEM_WORDS = 1024
) (
  input logic            clk,
  input logic            rst,
  lsu_byte_lane_if.slave bus
);

  localparam logic [32:0] ADDR_LIMIT = 33'(4 * MEM_WORDS);

  typedef enum logic {IDLE, RMW_WR} state_t;

  state_t      state_q, state_d;
  logic [31:0] merge_q, merge_d;
  logic [29:0] idx_q, idx_d;
  logic        fault_valid_q, fault_valid_d;
  logic [31:0] fault_addr_q, fault_addr_d;
  logic [1:0]  fault_cause_q, fault_cause_d;

  logic        is_byte, is_half, is_word;
  logic        illegal, misaligned, out_of_range;
  logic [1:0]  cause;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  assign is_byte = (bus.funct3[1:0] == 2'b00);
  assign is_half = (bus.funct3[1:0] == 2'b01);
  assign is_word = (bus.funct3 == 3'b010);

  // Stores only exist in signed-size encodings, so any 1xx store code is illegal.
  assign illegal      = (bus.funct3 == 3'b011) || (bus.funct3[2:1] == 2'b11) ||
                        (bus.we && bus.funct3[2]);
  assign misaligned   = (is_half && bus.addr[0]) || (is_word && (bus.addr[1:0] != 2'b00));
  assign out_of_range = ({1'b0, bus.addr} >= ADDR_LIMIT);

  always_comb begin
    cause = 2'b00;
    if (illegal)           cause = 2'b11;
    else if (misaligned)   cause = 2'b01;
    else if (out_of_range) cause = 2'b10;
  end

  assign byte_sel = bus.mem_RD[{bus.addr[1:0], 3'b000} +: 8];
  assign half_sel = bus.mem_RD[{bus.addr[1], 4'b0000} +: 16];

  always_comb begin
    state_d         = state_q;
    merge_d         = merge_q;
    idx_d           = idx_q;
    fault_valid_d   = fault_valid_q;
    fault_addr_d    = fault_addr_q;
    fault_cause_d   = fault_cause_q;
    bus.rdata       = 32'h0;
    bus.stall       = 1'b0;
    bus.fault_pulse = 1'b0;
    bus.mem_WE      = 1'b0;
    bus.mem_A       = {2'b00, bus.addr[31:2]};
    bus.mem_WD      = bus.wdata;

    // Outputs are held at their reset values while rst is low, which also aborts an RMW write.
    if (rst) begin
      if (state_q == RMW_WR) begin
        bus.mem_A  = {2'b00, idx_q};
        bus.mem_WD = merge_q;
        bus.mem_WE = 1'b1;
        state_d    = IDLE;
      end else if (bus.req) begin
        if (cause != 2'b00) begin
          bus.fault_pulse = 1'b1;
        end else if (!bus.we) begin
          case (bus.funct3)
            3'b000:  bus.rdata = {{24{byte_sel[7]}}, byte_sel};
            3'b001:  bus.rdata = {{16{half_sel[15]}}, half_sel};
            3'b010:  bus.rdata = bus.mem_RD;
            3'b100:  bus.rdata = {24'h0, byte_sel};
            3'b101:  bus.rdata = {16'h0, half_sel};
            default: bus.rdata = 32'h0;
          endcase
        end else if (is_word) begin
          bus.mem_WE = 1'b1;
        end else begin
          bus.stall = 1'b1;
          merge_d   = bus.mem_RD;
          if (is_byte) merge_d[{bus.addr[1:0], 3'b000} +: 8] = bus.wdata[7:0];
          else         merge_d[{bus.addr[1], 4'b0000} +: 16] = bus.wdata[15:0];
          idx_d     = bus.addr[31:2];
          state_d   = RMW_WR;
        end
      end

      // A fault arriving together with fault_clr replaces the old record.
      if (bus.fault_clr) fault_valid_d = 1'b0;
      if (bus.fault_pulse && (!fault_valid_q || bus.fault_clr)) begin
        fault_valid_d = 1'b1;
        fault_addr_d  = bus.addr;
        fault_cause_d = cause;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q       <= IDLE;
      merge_q       <= 32'h0;
      idx_q         <= 30'h0;
      fault_valid_q <= 1'b0;
      fault_addr_q  <= 32'h0;
      fault_cause_q <= 2'b00;
    end else begin
      state_q       <= state_d;
      merge_q       <= merge_d;
      idx_q         <= idx_d;
      fault_valid_q <= fault_valid_d;
      fault_addr_q  <= fault_addr_d;
      fault_cause_q <= fault_cause_d;
    end
  end

  assign bus.fault_valid = fault_valid_q;
  assign bus.fault_addr  = fault_addr_q;
  assign bus.fault_cause = fault_cause_q;

endmodule

// File: tb/tb_lsu_byte_lane.sv
// Directed bench for lsu_byte_lane: a byte-level reference model checked every cycle,
// plus literal expectations taken from hand-worked load/store/fault scenarios.
module tb_lsu_byte_lane;

  logic clk;
  logic rst;
  lsu_byte_lane_if bus();

  lsu_byte_lane #(.MEM_WORDS(1024)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int tests = 0;
  int fails = 0;

  logic [31:0] mem [1024];
  logic [31:0] ref_mem [1024];
  logic        pre_en;
  logic [9:0]  pre_idx;
  logic [31:0] pre_val;

  logic        m_pend;
  logic [31:0] m_paddr;
  int          m_psize;
  logic [31:0] m_pdata;
  logic        m_fv;
  logic [31:0] m_fa;
  logic [1:0]  m_fc;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign bus.mem_RD = (bus.mem_A < 32'd1024) ? mem[bus.mem_A[9:0]] : 32'h0;

  always @(posedge clk) begin
    if (pre_en) mem[pre_idx] <= pre_val;
    else if (bus.mem_WE && bus.mem_A < 32'd1024) mem[bus.mem_A[9:0]] <= bus.mem_WD;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s actual=%h required=%h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ref_byte(input logic [31:0] a);
    logic [31:0] w;
    w = ref_mem[a[11:2]];
    return 8'(w >> (8 * a[1:0]));
  endfunction

  // What the unit must do this cycle, derived from memory bytes and the access rules.
  function automatic void model_eval(output logic [31:0] e_rd, output logic e_st,
                                     output logic e_we, output logic e_pl,
                                     output logic [1:0] e_cs, output logic [31:0] e_a,
                                     output logic [31:0] e_wd);
    int n;
    logic [31:0] v;
    e_rd = 0; e_st = 0; e_we = 0; e_pl = 0; e_cs = 0;
    e_a = bus.addr / 4; e_wd = bus.wdata;
    if (m_pend) begin
      e_a = m_paddr / 4;
      v = ref_mem[m_paddr[11:2]];
      for (int i = 0; i < m_psize; i++) v[8 * ((m_paddr + i) % 4) +: 8] = m_pdata[8 * i +: 8];
      e_wd = v;
      e_we = 1;
      return;
    end
    if (!bus.req) return;
    n = (bus.funct3[1:0] == 0) ? 1 : (bus.funct3[1:0] == 1) ? 2 : 4;
    if (bus.funct3 == 3 || bus.funct3 == 6 || bus.funct3 == 7 || (bus.we && bus.funct3 >= 4))
      e_cs = 3;
    else if ((n == 2 && bus.addr % 2 != 0) || (n == 4 && bus.addr % 4 != 0))
      e_cs = 1;
    else if (bus.addr >= 4 * 1024)
      e_cs = 2;
    if (e_cs != 0) begin
      e_pl = 1;
      return;
    end
    if (!bus.we) begin
      v = 0;
      for (int i = 0; i < n; i++) v |= 32'(ref_byte(bus.addr + i)) << (8 * i);
      if (bus.funct3 < 4 && n < 4 && v[8 * n - 1]) v |= 32'hFFFF_FFFF << (8 * n);
      e_rd = v;
    end else if (n == 4) begin
      e_we = 1;
    end else begin
      e_st = 1;
    end
  endfunction

  always @(posedge clk or negedge rst) begin : model_update
    logic [31:0] e_rd, e_a, e_wd;
    logic e_st, e_we, e_pl;
    logic [1:0] e_cs;
    if (!rst) begin
      m_pend <= 0; m_fv <= 0; m_fa <= 0; m_fc <= 0;
      m_paddr <= 0; m_psize <= 0; m_pdata <= 0;
    end else begin
      model_eval(e_rd, e_st, e_we, e_pl, e_cs, e_a, e_wd);
      if (pre_en) ref_mem[pre_idx] <= pre_val;
      else if (e_we && e_a < 1024) ref_mem[e_a[9:0]] <= e_wd;
      if (m_pend) m_pend <= 0;
      else if (e_st) begin
        m_pend <= 1; m_paddr <= bus.addr; m_pdata <= bus.wdata;
        m_psize <= (bus.funct3[1:0] == 0) ? 1 : 2;
      end
      if (bus.fault_clr) m_fv <= 0;
      if (e_pl && (!m_fv || bus.fault_clr)) begin
        m_fv <= 1; m_fa <= bus.addr; m_fc <= e_cs;
      end
    end
  end

  always @(negedge clk) begin : compare
    logic [31:0] e_rd, e_a, e_wd;
    logic e_st, e_we, e_pl;
    logic [1:0] e_cs;
    if (rst) begin
      model_eval(e_rd, e_st, e_we, e_pl, e_cs, e_a, e_wd);
      chk("cmp_rdata", bus.rdata, e_rd);
      chk("cmp_stall", 32'(bus.stall), 32'(e_st));
      chk("cmp_mem_WE", 32'(bus.mem_WE), 32'(e_we));
      chk("cmp_fault_pulse", 32'(bus.fault_pulse), 32'(e_pl));
      chk("cmp_fault_valid", 32'(bus.fault_valid), 32'(m_fv));
      chk("cmp_fault_addr", bus.fault_addr, m_fa);
      chk("cmp_fault_cause", 32'(bus.fault_cause), 32'(m_fc));
      chk("cmp_mem_A", bus.mem_A, e_a);
      if (e_we) chk("cmp_mem_WD", bus.mem_WD, e_wd);
    end
  end

  task automatic step(input logic r, input logic w, input logic [2:0] f,
                      input logic [31:0] a, input logic [31:0] d, input logic c);
    @(posedge clk); #1;
    pre_en = 0;
    bus.req = r; bus.we = w; bus.funct3 = f; bus.addr = a; bus.wdata = d; bus.fault_clr = c;
    @(negedge clk);
  endtask

  task automatic preload(input logic [9:0] idx, input logic [31:0] val);
    @(posedge clk); #1;
    bus.req = 0; bus.fault_clr = 0;
    pre_en = 1; pre_idx = idx; pre_val = val;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout tests=%0d", tests);
    $fatal(1, "timeout");
  end

  initial begin
    for (int i = 0; i < 1024; i++) begin
      mem[i] = 32'h0;
      ref_mem[i] = 32'h0;
    end
    rst = 0; pre_en = 0; pre_idx = 0; pre_val = 0;
    bus.req = 0; bus.we = 0; bus.funct3 = 0; bus.addr = 32'h70; bus.wdata = 0; bus.fault_clr = 0;
    #2;
    chk("rst_rdata", bus.rdata, 32'h0);
    chk("rst_stall", 32'(bus.stall), 32'h0);
    chk("rst_mem_WE", 32'(bus.mem_WE), 32'h0);
    chk("rst_fault_valid", 32'(bus.fault_valid), 32'h0);
    chk("rst_fault_addr", bus.fault_addr, 32'h0);
    chk("rst_fault_cause", 32'(bus.fault_cause), 32'h0);
    chk("rst_fault_pulse", 32'(bus.fault_pulse), 32'h0);
    @(posedge clk); @(posedge clk); #1;
    rst = 1;

    // Loads with sign/zero extension
    preload(10'd28, 32'h0000_0020);
    step(1, 0, 3'b000, 32'h70, 0, 0); chk("lb_pos", bus.rdata, 32'h0000_0020);
    preload(10'd28, 32'h0000_80F0);
    step(1, 0, 3'b000, 32'h70, 0, 0); chk("lb_neg", bus.rdata, 32'hFFFF_FFF0);
    chk("lb_stall", 32'(bus.stall), 32'h0);
    step(1, 0, 3'b100, 32'h70, 0, 0); chk("lbu", bus.rdata, 32'h0000_00F0);
    step(1, 0, 3'b001, 32'h70, 0, 0); chk("lh", bus.rdata, 32'hFFFF_80F0);
    step(1, 0, 3'b101, 32'h70, 0, 0); chk("lhu", bus.rdata, 32'h0000_80F0);

    // sb read-modify-write, then back-to-back load
    preload(10'd28, 32'h0000_0020);
    step(1, 1, 3'b000, 32'h71, 32'h1234_56AB, 0);
    chk("sb_c1_stall", 32'(bus.stall), 32'h1);
    chk("sb_c1_we", 32'(bus.mem_WE), 32'h0);
    step(1, 1, 3'b000, 32'h71, 32'h1234_56AB, 0);
    chk("sb_c2_stall", 32'(bus.stall), 32'h0);
    chk("sb_c2_we", 32'(bus.mem_WE), 32'h1);
    chk("sb_c2_wd", bus.mem_WD, 32'h0000_AB20);
    chk("sb_c2_a", bus.mem_A, 32'd28);
    step(1, 0, 3'b010, 32'h70, 0, 0);
    chk("sb_lw_back", bus.rdata, 32'h0000_AB20);
    chk("sb_mem28", mem[28], 32'h0000_AB20);

    // sh and sw
    preload(10'd28, 32'h1122_3344);
    step(1, 1, 3'b001, 32'h72, 32'h0000_BEEF, 0);
    chk("sh_c1_stall", 32'(bus.stall), 32'h1);
    step(1, 1, 3'b001, 32'h72, 32'h0000_BEEF, 0);
    step(1, 0, 3'b010, 32'h70, 0, 0);
    chk("sh_lw_back", bus.rdata, 32'hBEEF_3344);
    step(1, 1, 3'b010, 32'h74, 32'hCAFE_F00D, 0);
    chk("sw_stall", 32'(bus.stall), 32'h0);
    chk("sw_we", 32'(bus.mem_WE), 32'h1);
    step(0, 0, 3'b000, 32'h74, 0, 0);
    chk("sw_mem29", mem[29], 32'hCAFE_F00D);

    // Faults: misaligned first, later faults do not overwrite
    step(1, 0, 3'b001, 32'h71, 0, 0);
    chk("mis_pulse", 32'(bus.fault_pulse), 32'h1);
    chk("mis_rdata", bus.rdata, 32'h0);
    chk("mis_we", 32'(bus.mem_WE), 32'h0);
    step(1, 1, 3'b010, 32'h1000, 32'h5555_5555, 0);
    chk("mis_valid", 32'(bus.fault_valid), 32'h1);
    chk("mis_addr", bus.fault_addr, 32'h71);
    chk("mis_cause", 32'(bus.fault_cause), 32'h1);
    chk("oor_pulse", 32'(bus.fault_pulse), 32'h1);
    step(0, 0, 3'b000, 32'h0, 0, 0);
    chk("keep_cause", 32'(bus.fault_cause), 32'h1);
    step(0, 0, 3'b000, 32'h0, 0, 1);
    step(1, 0, 3'b011, 32'h10, 0, 0);
    chk("clr_valid", 32'(bus.fault_valid), 32'h0);
    chk("ill_pulse", 32'(bus.fault_pulse), 32'h1);
    step(0, 0, 3'b000, 32'h0, 0, 0);
    chk("ill_cause", 32'(bus.fault_cause), 32'h3);
    chk("ill_addr", bus.fault_addr, 32'h10);

    // Out-of-range store colliding with fault_clr
    step(1, 1, 3'b000, 32'h1000, 32'h0000_0077, 1);
    chk("coll_we", 32'(bus.mem_WE), 32'h0);
    chk("coll_stall", 32'(bus.stall), 32'h0);
    step(0, 0, 3'b000, 32'h0, 0, 0);
    chk("coll_valid", 32'(bus.fault_valid), 32'h1);
    chk("coll_cause", 32'(bus.fault_cause), 32'h2);
    chk("coll_addr", bus.fault_addr, 32'h1000);

    // Reset asserted during the write cycle of an sb
    step(1, 1, 3'b000, 32'h70, 32'h0000_00FF, 0);
    chk("rr_c1_stall", 32'(bus.stall), 32'h1);
    @(posedge clk); #1;
    chk("rr_c2_we", 32'(bus.mem_WE), 32'h1);
    #2 rst = 0;
    #1;
    chk("rr_we_abort", 32'(bus.mem_WE), 32'h0);
    chk("rr_stall", 32'(bus.stall), 32'h0);
    chk("rr_rdata", bus.rdata, 32'h0);
    chk("rr_fault_valid", 32'(bus.fault_valid), 32'h0);
    chk("rr_fault_cause", 32'(bus.fault_cause), 32'h0);
    chk("rr_fault_addr", bus.fault_addr, 32'h0);
    bus.req = 0;
    @(posedge clk); #1;
    rst = 1;
    chk("rr_mem28", mem[28], 32'hBEEF_3344);
    step(1, 0, 3'b010, 32'h70, 0, 0);
    chk("rr_idle_lw", bus.rdata, 32'hBEEF_3344);
    chk("rr_idle_stall", 32'(bus.stall), 32'h0);
    step(0, 0, 3'b000, 32'h0, 0, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/lsu_byte_lane.md
# lsu_byte_lane

Load/store unit between the core's execute stage and the word-addressed data memory. It converts byte addresses into word indices and performs sign/zero extension for lb/lh/lw/lbu/lhu. Sub-word stores (sb/sh) are done as a two-cycle read-modify-write, with a one-cycle stall to the core. Illegal, misaligned and out-of-range accesses are suppressed, and the first one is recorded in a sticky fault register.

## Interface
- MEM_WORDS, 1024: data memory depth in 32-bit words. Valid byte addresses are 0 .. 4*MEM_WORDS-1.
- clk  in  1  single clock, all state on rising edge.
- rst  in  1  asynchronous, active-low reset.
- req  in  1  core access request this cycle.
- we  in  1  1 = store, 0 = load.
- funct3  in  3  RISC-V size code: 000 b, 001 h, 010 w, 100 bu, 101 hu.
- addr  in  32  byte address.
- wdata  in  32  store data, right-aligned.
- rdata  out  32  extended load result.
- stall  out  1  core must hold all inputs and the PC next edge.
- fault_pulse  out  1  current request was rejected (combinational).
- fault_valid  out  1  sticky: a fault has been captured.
- fault_addr  out  32  byte address of captured fault.
- fault_cause  out  2  01 misaligned, 10 out of range, 11 illegal funct3.
- fault_clr  in  1  clears fault_valid.
- mem_A  out  32  word index to memory, = addr>>2 zero-extended.
- mem_WD  out  32  memory write data.
- mem_WE  out  1  memory write enable. Memory writes on the rising edge.
- mem_RD  in  32  memory read data, combinational from mem_A.

## Operation
- FSM states are IDLE and RMW_WR. Reset forces IDLE.
- **Fault check** (combinational, on req in IDLE), highest priority first:
  - illegal funct3 (011, 110, 111; for stores also 1xx) -> cause 11.
  - misaligned (h with addr[0]=1; w with addr[1:0]≠0) -> cause 01.
  - out of range (addr ≥ 4*MEM_WORDS) -> cause 10.
- **Faulting request:** mem_WE=0, rdata=0, stall=0, fault_pulse=1. If fault_valid=0, capture addr/cause and set fault_valid next edge. If fault_valid=1, the first fault is kept.
- **Loads** (IDLE, no fault): single cycle, stall=0.
  - byte = mem_RD[8*addr[1:0] +: 8]; half = mem_RD[16*addr[1] +: 16].
  - b and h sign-extend; bu and hu zero-extend; w passes through.
- **sw** (IDLE, no fault): mem_WE=1, mem_WD=wdata, stall=0. Single cycle.
- **sb/sh** (IDLE, no fault):
  - Cycle 1: merge the wdata low byte/half into mem_RD at the lane selected by addr, register the merged word and word index, stall=1, mem_WE=0, go to RMW_WR.
  - Cycle 2 (RMW_WR): mem_A=registered index, mem_WD=merged word, mem_WE=1, stall=0. Core inputs are ignored. Return to IDLE.
- **req=0:** mem_WE=0 and rdata=0. mem_A still tracks addr.
- **fault_clr:** clears fault_valid next edge. If a new fault occurs in the same cycle, the new fault is captured and fault_valid stays 1.
- **Reset values:** state IDLE, stall 0, mem_WE 0, fault_valid 0, fault_addr 0, fault_cause 00, fault_pulse 0, rdata 0, merge registers 0.

## Timing
- Load latency 0: rdata is valid in the request cycle.
- sw commits on the edge that ends the request cycle.
- sb/sh commits on the edge that ends cycle 2. stall is high for exactly one cycle per sub-word store.
- A back-to-back load after sb/sh (issued in the cycle after RMW_WR) sees the merged data.
- Reset asserted during RMW_WR: the write is aborted (mem_WE forced 0 asynchronously), memory is unchanged, and the FSM is in IDLE on release.
- fault_valid, fault_addr and fault_cause update on the edge after the faulting cycle.

## Test plan
- **Loads:** word 28 = 0x00000020 (byte 0x70). lb 0x70 -> 0x00000020. Then preload 0x000080F0: lb 0x70 -> 0xFFFFFFF0; lbu 0x70 -> 0x000000F0; lh 0x70 -> 0xFFFF80F0; lhu 0x70 -> 0x000080F0. All with stall=0.
- **sb RMW:** word 28 = 0x00000020, sb wdata=0x123456AB at 0x71. Expect stall=1 for one cycle, mem_WE=1 only in cycle 2, word 28 = 0x0000AB20, and a following lw 0x70 returns 0x0000AB20.
- **sh/sw:** sh 0xBEEF at 0x72 over 0x11223344 -> 0xBEEF3344. sw 0xCAFEF00D at 0x74 -> single cycle, stall never asserted.
- **Faults:**
  - lh 0x71 -> fault_pulse=1, rdata=0, no write; next cycle fault_valid=1, fault_addr=0x71, cause 01.
  - Then sw 0x1000 -> cause retained as 01.
  - fault_clr, then funct3=011 -> cause 11.
- **Range/clear collision:** sb 0x1000 with fault_clr=1 in the same cycle -> fault_valid stays 1, cause 10, memory unchanged.
- **Reset mid-RMW:** sb 0xFF at 0x70, assert rst low during RMW_WR -> mem_WE=0 immediately, word 28 unchanged, all outputs at reset values, state IDLE after release.
